// File: rtl/noc_pkg.sv
// Shared constants, flit field helpers and the TX state type for the mesh
// traffic node.
package noc_pkg;
  localparam int DEST_FIXED = 0;
  localparam int DEST_RR    = 1;
  localparam int DEST_LFSR  = 2;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting right, feedback into bit 15
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

  function automatic int dest_lsb(input int dw, input int cw);
    return dw - 2*cw;
  endfunction

  function automatic int tail_bit(input int dw, input int cw);
    return dw - 2*cw - 1;
  endfunction

  // payload = {src, seq[7:0], flit_idx}
  function automatic int payload_w(input int cw, input int iw);
    return 2*cw + 8 + iw;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/noc_dest_sel.sv
// Destination generator: fixed, round-robin or LFSR, never targeting the
// node's own address in the generated modes.
module noc_dest_sel
  import noc_pkg::*;
#(
  parameter int                   COORD_W    = 2,
  parameter logic [2*COORD_W-1:0] POSITION   = '0,
  parameter int                   DEST_MODE  = DEST_FIXED,
  parameter logic [2*COORD_W-1:0] FIXED_DEST = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  output logic [2*COORD_W-1:0] next_dest
);
  localparam int AW = 2*COORD_W;
  localparam logic [AW-1:0] POS_P1 = POSITION + AW'(1);

  logic [15:0]   lfsr_q, lfsr_d;
  logic [AW-1:0] rr_q, rr_d;
  logic [AW-1:0] raw, skipped;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    raw    = FIXED_DEST;
    if (DEST_MODE == DEST_RR)
      raw = rr_q;
    else if (DEST_MODE == DEST_LFSR)
      raw = lfsr_q[AW-1:0];
    skipped   = (raw == POSITION) ? POS_P1 : raw;
    next_dest = (DEST_MODE == DEST_RR || DEST_MODE == DEST_LFSR) ? skipped : FIXED_DEST;
    // continue from the value actually used so a skip is not repeated
    rr_d = rr_q;
    if (advance)
      rr_d = skipped + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
      rr_q   <= POS_P1;
    end else begin
      lfsr_q <= lfsr_d;
      rr_q   <= rr_d;
    end
  end
endmodule

// File: rtl/ip_traffic_node.sv
// Local-port traffic node: periodic multi-flit packet injector plus a framing
// and address checking sink with saturating statistics.
module ip_traffic_node
  import noc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 37,
  parameter int                   COORD_W    = 2,
  parameter logic [2*COORD_W-1:0] POSITION   = 4'b0101,
  parameter int                   FREQ       = 4,
  parameter int                   PKT_LEN    = 4,
  parameter int                   DEST_MODE  = DEST_FIXED,
  parameter logic [2*COORD_W-1:0] FIXED_DEST = 4'b0000,
  parameter int                   CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rx_stall,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_w,
  input  logic                  tx_r,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_w,
  output logic                  rx_r,
  output logic [CNT_W-1:0]      sent_pkts,
  output logic [CNT_W-1:0]      recv_pkts,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  busy
);
  localparam int AW    = 2*COORD_W;
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GAP_W = (FREQ > 1) ? $clog2(FREQ) : 1;
  localparam int DLSB  = dest_lsb(DATA_WIDTH, COORD_W);
  localparam int TBIT  = tail_bit(DATA_WIDTH, COORD_W);
  localparam int PW    = payload_w(COORD_W, IDX_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(FREQ - 1);

  function automatic logic [DATA_WIDTH-1:0] mk_flit(input logic [AW-1:0]    dest,
                                                    input logic [7:0]       seq,
                                                    input logic [IDX_W-1:0] idx);
    logic [DATA_WIDTH-1:0] f;
    f                  = '0;
    f[DLSB +: AW]      = dest;
    f[TBIT]            = (idx == LAST_IDX);
    f[PW-1:0]          = {POSITION, seq, idx};
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  tx_state_e             state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seq_q, seq_d;
  logic [AW-1:0]         dest_q, dest_d, next_dest;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]      sent_q, sent_d, recv_q, recv_d, err_q, err_d;
  logic [IDX_W-1:0]      exp_q, exp_d;
  logic                  advance, tx_acc, tx_tail;
  logic                  rx_acc, rx_tail, rx_err;
  logic [AW-1:0]         rx_dest;
  logic [IDX_W-1:0]      rx_idx;
  logic                  unused_rx;

  noc_dest_sel #(
    .COORD_W    (COORD_W),
    .POSITION   (POSITION),
    .DEST_MODE  (DEST_MODE),
    .FIXED_DEST (FIXED_DEST)
  ) u_dest (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .next_dest (next_dest)
  );

  assign tx_acc  = (state_q == TX_SEND) && tx_r;
  assign tx_tail = tx_acc && (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    dest_d    = dest_q;
    tx_data_d = tx_data_q;
    sent_d    = sent_q;
    advance   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        // gap parks at its last value while enable is low
        if (gap_q == LAST_GAP) begin
          if (enable) begin
            state_d   = TX_SEND;
            advance   = 1'b1;
            dest_d    = next_dest;
            idx_d     = '0;
            tx_data_d = mk_flit(next_dest, seq_q, '0);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      TX_SEND: begin
        if (tx_tail) begin
          state_d   = TX_IDLE;
          gap_d     = '0;
          seq_d     = seq_q + 8'd1;
          sent_d    = sat_inc(sent_q);
          tx_data_d = '0;
        end else if (tx_acc) begin
          idx_d     = idx_q + IDX_W'(1);
          tx_data_d = mk_flit(dest_q, seq_q, idx_d);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign rx_r      = !rx_stall;
  assign rx_acc    = rx_w && rx_r;
  assign rx_dest   = rx_data[DLSB +: AW];
  assign rx_tail   = rx_data[TBIT];
  assign rx_idx    = rx_data[IDX_W-1:0];
  assign unused_rx = ^rx_data;

  always_comb begin
    exp_d  = exp_q;
    recv_d = recv_q;
    err_d  = err_q;
    rx_err = (rx_dest != POSITION) || (rx_idx != exp_q) ||
             (rx_tail != (rx_idx == LAST_IDX));
    if (rx_acc) begin
      // resynchronise on whatever arrived, good or bad
      exp_d = rx_tail ? '0 : rx_idx + IDX_W'(1);
      if (rx_err)
        err_d = sat_inc(err_q);
      if (rx_tail)
        recv_d = sat_inc(recv_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      gap_q     <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      dest_q    <= '0;
      tx_data_q <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      err_q     <= '0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      dest_q    <= dest_d;
      tx_data_q <= tx_data_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      err_q     <= err_d;
      exp_q     <= exp_d;
    end
  end

  assign tx_w      = (state_q == TX_SEND);
  assign busy      = (state_q == TX_SEND);
  assign tx_data   = tx_data_q;
  assign sent_pkts = sent_q;
  assign recv_pkts = recv_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_ip_traffic_node.sv
// Directed bench for ip_traffic_node: TX flits and round-robin destinations
// are scored against queues of expected values; RX statistics checked inline.
module tb_ip_traffic_node;
  localparam int DW = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, rx_stall, tx_w, tx_r, rx_w, rx_r, busy;
  logic [DW-1:0] tx_data, rx_data;
  logic [15:0]   sent_pkts, recv_pkts, err_cnt;

  logic          reset1, tx_w1;
  logic [DW-1:0] tx_data1;
  logic          unused_rx_r1, unused_busy1;
  logic [15:0]   unused_sent1, unused_recv1, unused_err1;

  int checks = 0;
  int errors = 0;
  int rr_seen = 0;
  logic [DW-1:0] exp_tx[$];
  logic [3:0]    exp_rr[$];

  ip_traffic_node dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_stall(rx_stall),
    .tx_data(tx_data), .tx_w(tx_w), .tx_r(tx_r),
    .rx_data(rx_data), .rx_w(rx_w), .rx_r(rx_r),
    .sent_pkts(sent_pkts), .recv_pkts(recv_pkts), .err_cnt(err_cnt), .busy(busy)
  );

  ip_traffic_node #(.DEST_MODE(1)) dut_rr (
    .clk(clk), .reset(reset1), .enable(1'b1), .rx_stall(1'b0),
    .tx_data(tx_data1), .tx_w(tx_w1), .tx_r(1'b1),
    .rx_data({DW{1'b0}}), .rx_w(1'b0), .rx_r(unused_rx_r1),
    .sent_pkts(unused_sent1), .recv_pkts(unused_recv1), .err_cnt(unused_err1),
    .busy(unused_busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Flit as laid out for POSITION=0101, COORD_W=2, IDX_W=2
  function automatic logic [DW-1:0] flit(input logic [3:0] d, input logic t,
                                         input logic [7:0] s, input logic [1:0] i);
    logic [DW-1:0] f;
    f        = '0;
    f[36:33] = d;
    f[32]    = t;
    f[13:0]  = {4'b0101, s, i};
    return f;
  endfunction

  task automatic push_pkt(input logic [3:0] d, input logic [7:0] s);
    for (int i = 0; i < 4; i++) exp_tx.push_back(flit(d, i == 3, s, 2'(i)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_pkt(input logic [3:0] d, input logic with_tail);
    for (int i = 0; i < 4; i++) begin
      rx_data = flit(d, (i == 3) && with_tail, 8'h00, 2'(i));
      rx_w    = 1'b1;
      tick();
    end
    rx_w = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && tx_w && tx_r) begin
      if (exp_tx.size() == 0) chk("tx_extra_flit", 64'(exp_tx.size()), 64'd1);
      else chk("tx_flit", tx_data, exp_tx.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset1 && tx_w1 && tx_data1[1:0] == 2'd0 && exp_rr.size() > 0) begin
      chk("rr_dest", tx_data1[36:33], exp_rr.pop_front());
      rr_seen++;
    end
  end

  initial begin
    logic [3:0] d;
    reset = 1'b0; reset1 = 1'b0; enable = 1'b1; tx_r = 1'b1;
    rx_stall = 1'b0; rx_w = 1'b0; rx_data = '0;
    d = 4'd6;
    for (int i = 0; i < 16; i++) begin
      if (d == 4'd5) d = 4'd6;
      exp_rr.push_back(d);
      d = d + 4'd1;
    end
    tick(); tick();
    chk("rst_tx_w", tx_w, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent_pkts, 0);
    chk("rst_recv", recv_pkts, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_rx_r", rx_r, 1);

    push_pkt(4'd0, 8'd0);
    push_pkt(4'd0, 8'd1);
    reset = 1'b1; reset1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("tx_w_c%0d", k), tx_w, (k >= 4 && k <= 7) || k == 12);
      if (k == 5) chk("busy_send", busy, 1);
      if (k == 7) chk("sent_before_tail", sent_pkts, 0);
      if (k == 8) chk("sent_after_tail", sent_pkts, 1);
    end

    tick();  // point 13: flit 1 of packet seq 1 on the bus
    tx_r = 1'b0;
    for (int k = 14; k <= 16; k++) begin
      tick();
      chk($sformatf("stall_w_c%0d", k), tx_w, 1);
      chk($sformatf("stall_data_c%0d", k), tx_data, flit(4'd0, 1'b0, 8'd1, 2'd1));
    end
    tx_r = 1'b1;
    tick(); tick();
    chk("sent_stalled_pkt_pending", sent_pkts, 1);
    tick();
    chk("sent_stalled_pkt_done", sent_pkts, 2);
    chk("idle_after_stall", tx_w, 0);
    push_pkt(4'd0, 8'd2);

    for (int k = 20; k <= 25; k++) tick();
    chk("flit2_before_reset", tx_data, flit(4'd0, 1'b0, 8'd2, 2'd2));
    reset = 1'b0;
    #1;
    chk("reset_drops_tx_w", tx_w, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sent", sent_pkts, 0);
    exp_tx.delete();
    tick();
    push_pkt(4'd0, 8'd0);
    reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4) begin
        chk("restart_tx_w", tx_w, 1);
        chk("restart_flit0", tx_data, flit(4'd0, 1'b0, 8'd0, 2'd0));
        enable = 1'b0;
      end
      if (k == 8) chk("restart_sent", sent_pkts, 1);
    end
    chk("disabled_idle", tx_w, 0);
    chk("tx_queue_drained", 64'(exp_tx.size()), 0);

    rx_pkt(4'd5, 1'b1);
    chk("rx_good_recv", recv_pkts, 1);
    chk("rx_good_err", err_cnt, 0);
    rx_pkt(4'd0, 1'b1);
    chk("rx_baddest_recv", recv_pkts, 2);
    chk("rx_baddest_err", err_cnt, 4);
    rx_pkt(4'd5, 1'b0);
    chk("rx_notail_recv", recv_pkts, 2);
    chk("rx_notail_err", err_cnt, 5);
    rx_pkt(4'd5, 1'b1);
    chk("rx_resync_recv", recv_pkts, 3);
    chk("rx_resync_err", err_cnt, 5);

    rx_stall = 1'b1;
    rx_data  = flit(4'd0, 1'b0, 8'h00, 2'd0);
    rx_w     = 1'b1;
    #1;
    chk("rx_r_stalled", rx_r, 0);
    tick(); tick();
    chk("stall_err_hold", err_cnt, 5);
    chk("stall_recv_hold", recv_pkts, 3);
    rx_stall = 1'b0;
    tick();
    chk("unstall_accept", err_cnt, 6);
    rx_w = 1'b0;
    tick();
    chk("unstall_single", err_cnt, 6);

    for (int k = 0; k < 400 && exp_rr.size() > 0; k++) tick();
    chk("rr_count", rr_seen, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ip_traffic_node.md
# ip_traffic_node

Parametrised traffic producer/consumer for the local port of a mesh switch; next-generation replacement for the fixed-behaviour local IP model. Injects multi-flit packets at a programmable period with fixed, round-robin or pseudo-random destinations, sinks flits from the switch, checks packet framing and addressing, and exposes saturating statistics counters. It sits between a switch's local port (L) and the tile's status logic.

## Interface
- DATA_WIDTH, 37, flit width; must satisfy DATA_WIDTH ≥ 4*COORD_W + 9 + IDX_W
- COORD_W, 2, bits per X/Y coordinate; mesh is 2**COORD_W × 2**COORD_W
- POSITION, 4'b0101, own address {X,Y}, width 2*COORD_W
- FREQ, 4, idle cycles between packets, ≥1
- PKT_LEN, 4, flits per packet, ≥1; IDX_W = max(1, clog2(PKT_LEN))
- DEST_MODE, 0, 0 fixed, 1 round-robin, 2 LFSR
- FIXED_DEST, 4'b0000, destination in mode 0
- CNT_W, 16, statistics counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  permit new packet injection
- rx_stall  in  1  force rx_r low (backpressure test)
- tx_data  out  DATA_WIDTH  flit to switch local input
- tx_w  out  1  tx_data valid
- tx_r  in  1  switch can accept
- rx_data  in  DATA_WIDTH  flit from switch local output
- rx_w  in  1  rx_data valid
- rx_r  out  1  node can accept
- sent_pkts, recv_pkts, err_cnt  out  CNT_W each  saturating counters
- busy  out  1  TX state is SEND

## Operation
- Flit fields: [DATA_WIDTH-1 -: 2*COORD_W] destination; next bit tail; low bits payload {src POSITION, seq[7:0], flit_idx[IDX_W-1:0]}; unused bits zero.
- Transfer on a rising edge where w && r; writer holds data and w until accepted.
- TX FSM, IDLE / SEND. IDLE: gap counter increments each cycle; at gap == FREQ-1 with enable high, latch destination, flit_idx=0, go SEND. enable low in IDLE holds counter at FREQ-1.
- SEND: tx_w=1, tx_data registered. On accept: flit_idx++; tail set when flit_idx == PKT_LEN-1. On tail accept: sent_pkts++, seq++ (wraps 8 bits), gap=0, go IDLE. Deasserting enable never truncates a packet.
- Destination: mode 0 FIXED_DEST; mode 1 counter starting at POSITION+1, increments per packet, wraps 2**(2*COORD_W); mode 2 low 2*COORD_W bits of 16-bit LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1, steps every cycle). Modes 1/2: a value equal to POSITION is replaced by POSITION+1 (wrapping).
- RX: rx_r = !rx_stall. Expected index starts 0. Per accepted flit, one error if any of: dest ≠ POSITION; flit_idx ≠ expected; tail ≠ (flit_idx == PKT_LEN-1). err_cnt increments at most once per flit. Resync: expected = tail ? 0 : flit_idx+1. Tail flit increments recv_pkts, even if erroneous.
- Counters saturate at all-ones.

## Timing
- Reset: tx_w=0, tx_data=0, busy=0, counters 0, gap=0, seq=0, expected=0, LFSR=seed, RR=POSITION+1; rx_r follows rx_stall combinationally. Reset mid-packet drops tx_w immediately; partial packet abandoned.
- After reset release with enable high: tx_w rises on the edge ending the FREQ-th cycle.
- Unstalled packet interval: FREQ + PKT_LEN cycles; 1 flit/cycle in SEND.
- Counters update on the edge of the causing handshake, visible next cycle.
- Simultaneous TX tail accept and RX tail: both counters update same edge.

## Structure
- Package noc_pkg: DEST_FIXED/DEST_RR/DEST_LFSR constants, flit field offset functions (dest, tail, payload), LFSR seed/taps, tx state enum.
- One sub-module, noc_dest_sel: RR counter, LFSR, own-address skip; outputs next destination, advance strobe in.

## Test plan
- Defaults, mode 0, FIXED_DEST=4'b0000, tx_r=1: tx_w high cycles 4–7, flit_idx 0..3, tail only on 3, dest 0000, next packet cycle 12; sent_pkts=1 after first tail.
- tx_r low 3 cycles mid-packet: tx_data/tx_w held stable, no index skip, packet completes 3 cycles late.
- Mode 1, POSITION=0101: destinations 0110,0111,…,1111,0000,…,0100,0110 (0101 skipped).
- RX well-formed 4-flit packet to 0101 then one with wrong dest and one with missing tail on idx 3: recv_pkts=2, err_cnt=1+4+… per rule (exact: 4 dest errors, 1 tail error; resync holds).
- rx_stall=1 with rx_w=1: rx_r=0, no counter change; release → accept next edge.
- reset asserted during flit 2: tx_w low immediately; after release, new packet starts idx 0, seq 0.
